// File: rtl/alu_mul_seq.sv
// Shift-and-add 16x16 multiplier that borrows the shared Hack ALU.
// Product is the low WIDTH bits, valid for signed and unsigned operands.
module alu_mul_seq #(
    parameter int WIDTH = 16,
    parameter int ITER  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product,
    output logic [WIDTH-1:0] alu_x,
    output logic [WIDTH-1:0] alu_y,
    output logic             alu_zx,
    output logic             alu_nx,
    output logic             alu_zy,
    output logic             alu_ny,
    output logic             alu_f,
    output logic             alu_no,
    input  logic [WIDTH-1:0] alu_out
);

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DBL,
        DONE
    } state_t;

    localparam logic [4:0] LAST = 5'(ITER - 1);
    localparam logic [5:0] OP_ADD = 6'b000010;
    localparam logic [5:0] OP_ZERO = 6'b101010;

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [4:0]       cnt;
    logic [5:0]       ctrl;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            acc     <= '0;
            a_sh    <= '0;
            b_sh    <= '0;
            cnt     <= '0;
            product <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        acc   <= '0;
                        a_sh  <= a;
                        b_sh  <= b;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= ADD;
                    end
                end
                ADD: begin
                    if (b_sh[0]) acc <= alu_out;
                    state <= DBL;
                end
                DBL: begin
                    a_sh <= alu_out;
                    b_sh <= b_sh >> 1;
                    cnt  <= cnt + 5'd1;
                    if (cnt == LAST) begin
                        product <= acc;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end else begin
                        state <= ADD;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Operand/control drive depends only on state and registers, never on alu_out.
    always_comb begin
        alu_x = '0;
        alu_y = '0;
        ctrl  = OP_ZERO;
        unique case (state)
            ADD: begin
                alu_x = acc;
                alu_y = a_sh;
                ctrl  = OP_ADD;
            end
            DBL: begin
                alu_x = a_sh;
                alu_y = a_sh;
                ctrl  = OP_ADD;
            end
            default: begin
                alu_x = '0;
                alu_y = '0;
                ctrl  = OP_ZERO;
            end
        endcase
    end

    assign {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = ctrl;

endmodule

// File: doc/alu_mul_seq.md
Name: alu_mul_seq

Overview:
- Multi-cycle sequencer that computes a 16x16 -> 16-bit product (mod 2^16) using only the shared Hack ALU, by shift-and-add.
- Drives the ALU operand buses and the six control bits (zx, nx, zy, ny, f, no), and samples the ALU result.
- Gives a multiply capability without adding a hardware multiplier. The ALU instance stays outside the block.
- Sits beside the CPU datapath; the CPU owns the ALU mux and hands it to this block while busy is high.

Parameters:
- WIDTH, 16, operand/result width. It must match the ALU; only 16 is supported.
- ITER, 16, number of multiplier bits processed. Must equal WIDTH.

Ports:
- clk  input  1  system clock, all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request a multiply; sampled only in IDLE
- a  input  16  multiplicand, captured on the accepted start
- b  input  16  multiplier, captured on the accepted start
- busy  output  1  high in ADD and DBL states
- done  output  1  one-cycle pulse in the DONE state
- product  output  16  result register, held until the next accepted start or reset
- alu_x  output  16  ALU x operand
- alu_y  output  16  ALU y operand
- alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no  output  1 each  ALU control bits
- alu_out  input  16  ALU result, combinational from alu_x, alu_y and the control bits

Behaviour:
- One clock, clk. reset is synchronous and active-high.
- Reset, and any cycle with reset high (including mid-operation):
  - state=IDLE; acc, a_sh, b_sh, cnt = 0; product=0; busy=0; done=0.
  - Reset overrides start in the same cycle.
- Registers:
  - acc[15:0]: accumulator.
  - a_sh[15:0]: shifted multiplicand.
  - b_sh[15:0]: multiplier, shifted right.
  - cnt[4:0]: bit counter.
- FSM states: IDLE, ADD, DBL, DONE.
- IDLE:
  - busy=0, done=0.
  - On start=1: acc<=0, a_sh<=a, b_sh<=b, cnt<=0, go to ADD.
- ADD:
  - Drives alu_x=acc, alu_y=a_sh, controls 000010 (x+y).
  - acc <= b_sh[0] ? alu_out : acc. Go to DBL.
- DBL:
  - Drives alu_x=a_sh, alu_y=a_sh, controls 000010 (x+y).
  - a_sh <= alu_out, b_sh <= b_sh>>1 (zero fill), cnt <= cnt+1.
  - If cnt==ITER-1, go to DONE and set product <= acc. Otherwise go to ADD.
- DONE:
  - done=1, busy=0. Go to IDLE unconditionally.
  - start in DONE is ignored; the requester re-asserts it in IDLE.
- IDLE and DONE ALU drive: alu_x=0, alu_y=0, controls 101010 (constant 0). No ALU result is consumed.
- ALU control outputs are order zx,nx,zy,ny,f,no. They and alu_x/alu_y are combinational from state and registers only (no start or alu_out feed-through), so there are no combinational loops.
- Latency:
  - Fixed, with no early-out on zero multiplier bits.
  - start accepted at edge E0. The ADD/DBL pairs occupy edges E1..E32. product is updated at E32, and done is high during the cycle after E32. At E33 the block is back in IDLE.
  - Throughput is one multiply per 34 cycles, including the IDLE accept cycle.
- Arithmetic:
  - All sums wrap mod 2^16; a_sh doubling discards the carry-out.
  - The result equals the low 16 bits of a*b. This is correct for both two's-complement signed and unsigned operands. No overflow flag.
- start while busy or done is ignored, and a/b changes mid-operation have no effect (operands are captured).
- product changes only at the E32 edge or on reset. It is stable during done and afterwards.

Test Plan:
- Reset, then a=3, b=5, start for 1 cycle -> busy=1 for 32 cycles; done pulses exactly 32 cycles after the start edge; product=0x000F; busy=0 during done.
- a=0xFFF9 (-7), b=0x0006 -> product=0xFFD6 (-42). Then a=0xFFFF, b=0xFFFF -> product=0x0001.
- a=0x0100, b=0x0100 -> product=0x0000 (wrap). Then a=0x1234, b=0 -> product=0; latency is still 32 cycles.
- Start a=3, b=5; at cycle 10 pulse start with a=9, b=9, and change a/b -> ignored; product=0x000F, done only once.
- Start a=3, b=5; assert reset at cycle 10 -> the next cycle shows busy=0, done=0, product=0 and ALU controls 101010. A new start with a=4, b=4 -> product=0x0010 after 32 cycles.
- Each ADD/DBL cycle: controls equal 000010. With a bench alu instance connected, add random-operand checks (100 pairs) against (a*b)&0xFFFF.
